// File: rtl/vector_sweep_misr.sv
// vector_sweep_misr: exhaustive IN_W-bit stimulus sweep folding the DUT response into a 32-bit MISR; define SWEEP_PAUSE_EN for the pause input
module vector_sweep_misr #(
   parameter int IN_W  = 4,
   parameter int OUT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
`ifdef SWEEP_PAUSE_EN
   input  logic             pause,
`endif
   output logic [IN_W-1:0]  dut_a,
   input  logic [OUT_W-1:0] dut_y,
   output logic             busy,
   output logic             done,
   output logic [31:0]      signature,
   output logic [IN_W:0]    vec_count
);
   localparam int          NCH  = (OUT_W + 31) / 32;
   localparam logic [31:0] POLY = 32'h04C11DB7;
   typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;
   state_t              state, state_nx;
   logic                adv, last;
   logic [NCH*32-1:0]   y_pad;
   logic [31:0]         f, sig_nx;
`ifdef SWEEP_PAUSE_EN
   assign adv = state == SWEEP && !pause;
`else
   assign adv = state == SWEEP;
`endif
   assign last  = dut_a == {IN_W{1'b1}};
   assign y_pad = (NCH*32)'(dut_y);
   assign busy  = state == SWEEP;
   assign done  = state == DONE;
   // xor the zero-padded 32-bit response chunks, then step the CRC-32 shift register
   always_comb begin
      f = '0;
      for (int i = 0; i < NCH; i++) f = f ^ y_pad[i*32 +: 32];
      sig_nx = {signature[30:0], 1'b0} ^ (signature[31] ? POLY : 32'h0) ^ f;
   end
   // sweep ends on the fold of the all-ones vector; DONE always lasts one cycle
   always_comb begin
      state_nx = state == IDLE  ? (start ? SWEEP : IDLE) :
                 state == SWEEP ? (adv && last ? DONE : SWEEP) : IDLE;
   end
   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   end
   // stimulus, vector count and signature; dut_a wraps to 0 on the final fold
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dut_a     <= '0;
         vec_count <= '0;
         signature <= '0;
      end else if (state == IDLE && start) begin
         dut_a     <= '0;
         vec_count <= '0;
         signature <= 32'hFFFFFFFF;
      end else if (adv) begin
         dut_a     <= dut_a + IN_W'(1);
         vec_count <= vec_count + (IN_W+1)'(1);
         signature <= sig_nx;
      end
   end
endmodule
